// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Source indices name the fixed producers wired to the arbiter's request ports.
package wb_arbiter_pkg;

  // Fixed writeback producer slots; lower index wins under fixed priority
  localparam int WB_SRC_ALU = 0;
  localparam int WB_SRC_LSU = 1;
  localparam int WB_SRC_CSR = 2;

  // Default geometry matching the core's register file
  localparam int WB_N_SRC_DEFAULT  = 3;
  localparam int WB_ADDR_W_DEFAULT = 5;
  localparam int WB_DATA_W_DEFAULT = 32;

  // Width of grant_id and of the round-robin pointer (covers up to 8 sources)
  localparam int WB_IDX_W = 3;

  // Advance a source index by one, wrapping at n_src-1 back to zero
  function automatic logic [WB_IDX_W-1:0] wb_next_idx(
    input logic [WB_IDX_W-1:0] idx,
    input int                  n_src
  );
    if (idx == WB_IDX_W'(n_src - 1)) begin
      return '0;
    end
    return idx + WB_IDX_W'(1);
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational N-way picker for the writeback arbiter.
// Searches req starting at ptr and wrapping, returning the first hit as a
// one-hot grant plus its encoded index. With ptr tied to zero this is a plain
// lowest-index-wins priority picker.
module wb_arbiter_rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int N     = WB_N_SRC_DEFAULT,
  parameter int IDX_W = WB_IDX_W
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic             hi_found;
  logic             lo_found;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // First requester at or above ptr wins; otherwise wrap to the lowest requester
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !hi_found && (IDX_W'(i) >= ptr)) begin
        hi_found = 1'b1;
        hi_idx   = IDX_W'(i);
      end
      if (req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
    any       = hi_found | lo_found;
    grant_idx = hi_found ? hi_idx : lo_idx;
    grant     = any ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: shares the single regfile write port among
// N_SRC valid/ready producers (ALU, load unit, CSR unit). One request is
// accepted per cycle and registered onto wr_addr/wr_data/wr_enable, so a
// transfer at posedge N is committed by the regfile at posedge N+1.
// Writes to x0 are accepted but discarded, flagged by a one-cycle x0_drop.
// Build option: define WB_RR_EN for round-robin arbitration; otherwise the
// lowest source index always wins and no pointer register is built.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_SRC  = WB_N_SRC_DEFAULT,
  parameter int ADDR_W = WB_ADDR_W_DEFAULT,
  parameter int DATA_W = WB_DATA_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        src_valid,
  output logic [N_SRC-1:0]        src_ready,
  input  logic [N_SRC*ADDR_W-1:0] src_addr,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic                    wb_stall,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic                    wr_enable,
  output logic [WB_IDX_W-1:0]     grant_id,
  output logic                    x0_drop
);

  logic [N_SRC-1:0]    pick_req;
  logic [N_SRC-1:0]    pick_grant;
  logic [WB_IDX_W-1:0] win_idx;
  logic                xfer;
  logic [WB_IDX_W-1:0] rr_ptr;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;

  // Nothing may be granted during reset or stall, so the picker sees no requests
  assign pick_req  = (reset || wb_stall) ? '0 : src_valid;
  assign src_ready = pick_grant;

  wb_arbiter_rr_pick #(
    .N     (N_SRC),
    .IDX_W (WB_IDX_W)
  ) u_pick (
    .req       (pick_req),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (win_idx),
    .any       (xfer)
  );

  // Select the winning source's address and data from the packed request buses
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (pick_grant[i]) begin
        win_addr = src_addr[i*ADDR_W +: ADDR_W];
        win_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef WB_RR_EN
  // Rotate the search start to just past the winner after every transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= wb_next_idx(win_idx, N_SRC);
    end
  end
`else
  assign rr_ptr = '0;
`endif

  // Register the accepted write; x0 targets are consumed without a regfile write
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_enable <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      grant_id  <= '0;
      x0_drop   <= 1'b0;
    end else if (xfer) begin
      grant_id <= win_idx;
      if (win_addr != '0) begin
        wr_enable <= 1'b1;
        wr_addr   <= win_addr;
        wr_data   <= win_data;
        x0_drop   <= 1'b0;
      end else begin
        wr_enable <= 1'b0;
        x0_drop   <= 1'b1;
      end
    end else begin
      wr_enable <= 1'b0;
      x0_drop   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (3 sources, 5-bit addr, 32-bit data).
// Expectations follow the WB_RR_EN setting the bench is compiled with.
module tb_wb_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  src_valid;
  logic [2:0]  src_ready;
  logic [14:0] src_addr;
  logic [95:0] src_data;
  logic        wb_stall;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_enable;
  logic [2:0]  grant_id;
  logic        x0_drop;

  logic [4:0]  addr_v [3];
  logic [31:0] data_v [3];

  int total = 0;
  int bad   = 0;

  wb_arbiter #(
    .N_SRC  (3),
    .ADDR_W (5),
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .wb_stall  (wb_stall),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_enable (wr_enable),
    .grant_id  (grant_id),
    .x0_drop   (x0_drop)
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive request inputs from the per-source tables and let combinational logic settle
  task automatic applyStimulus(input logic [2:0] valid, input logic stall,
                               input logic rst);
    reset     = rst;
    wb_stall  = stall;
    src_valid = valid;
    for (int i = 0; i < 3; i++) begin
      src_addr[i*5 +: 5]   = addr_v[i];
      src_data[i*32 +: 32] = data_v[i];
    end
    #1;
  endtask

  // Advance past the next rising edge so registered outputs are stable
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Check the full registered write-port state after a cycle
  task automatic checkWrite(input string tag, input logic en, input logic [4:0] a,
                            input logic [31:0] d, input logic [2:0] g, input logic x0);
    checkOutput({tag, ".wr_enable"}, 32'(wr_enable), 32'(en));
    checkOutput({tag, ".wr_addr"},   32'(wr_addr),   32'(a));
    checkOutput({tag, ".wr_data"},   wr_data,        d);
    checkOutput({tag, ".grant_id"},  32'(grant_id),  32'(g));
    checkOutput({tag, ".x0_drop"},   32'(x0_drop),   32'(x0));
  endtask

  int          w;
  int          exp_w [4];
  logic [2:0]  exp_ready;

  initial begin
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = '0;
      data_v[i] = '0;
    end
    reset     = 1'b1;
    wb_stall  = 1'b0;
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
    @(negedge clk);

    // Reset holds off all grants even with every source requesting
    applyStimulus(3'b111, 1'b0, 1'b1);
    checkOutput("reset.ready", 32'(src_ready), 32'h0);
    tick();
    checkOutput("reset.ready2", 32'(src_ready), 32'h0);
    tick();
    checkWrite("reset", 1'b0, 5'd0, 32'h0, 3'd0, 1'b0);

    // Single load-unit write
    addr_v[1] = 5'd5;
    data_v[1] = 32'hDEADBEEF;
    applyStimulus(3'b010, 1'b0, 1'b0);
    checkOutput("single.ready", 32'(src_ready), 32'h2);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkWrite("single", 1'b1, 5'd5, 32'hDEADBEEF, 3'd1, 1'b0);
    tick();
    checkOutput("idle.wr_enable", 32'(wr_enable), 32'h0);
    checkOutput("idle.wr_addr_hold", 32'(wr_addr), 32'd5);

    // Contention from reset: all three held valid for four cycles
    applyStimulus(3'b111, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      addr_v[i] = 5'(i + 1);
      data_v[i] = 32'h100 + 32'(i);
    end
`ifdef WB_RR_EN
    exp_w = '{0, 1, 2, 0};
`else
    exp_w = '{0, 0, 0, 0};
`endif
    for (int c = 0; c < 4; c++) begin
      w = exp_w[c];
      exp_ready = 3'b001 << w;
      applyStimulus(3'b111, 1'b0, 1'b0);
      checkOutput($sformatf("contend%0d.ready", c), 32'(src_ready), 32'(exp_ready));
      tick();
      checkWrite($sformatf("contend%0d", c), 1'b1, 5'(w + 1), 32'h100 + 32'(w),
                 3'(w), 1'b0);
    end

    // Write to x0 is accepted and dropped; address register holds
    addr_v[0] = 5'd0;
    data_v[0] = 32'h1234;
    applyStimulus(3'b001, 1'b0, 1'b0);
    checkOutput("x0.ready", 32'(src_ready), 32'h1);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkOutput("x0.wr_enable", 32'(wr_enable), 32'h0);
    checkOutput("x0.x0_drop",   32'(x0_drop),   32'h1);
    checkOutput("x0.grant_id",  32'(grant_id),  32'h0);
    checkOutput("x0.wr_addr",   32'(wr_addr),   32'd1);
    tick();
    checkOutput("x0.pulse_end", 32'(x0_drop), 32'h0);

    // Stall holds the CSR request off for three cycles
    addr_v[2] = 5'd7;
    data_v[2] = 32'h77;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(3'b100, 1'b1, 1'b0);
      checkOutput($sformatf("stall%0d.ready", c), 32'(src_ready), 32'h0);
      tick();
      checkOutput($sformatf("stall%0d.wr_enable", c), 32'(wr_enable), 32'h0);
    end
    applyStimulus(3'b100, 1'b0, 1'b0);
    checkOutput("unstall.ready", 32'(src_ready), 32'h4);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkWrite("unstall", 1'b1, 5'd7, 32'h77, 3'd2, 1'b0);

    // Reset mid-stream clears the pending write and the pointer
    addr_v[0] = 5'd9;
    data_v[0] = 32'h99;
    addr_v[1] = 5'd10;
    data_v[1] = 32'hAA;
    applyStimulus(3'b011, 1'b0, 1'b0);
    checkOutput("mid.ready0", 32'(src_ready), 32'h1);
    tick();
    applyStimulus(3'b011, 1'b0, 1'b1);
    checkWrite("mid.first", 1'b1, 5'd9, 32'h99, 3'd0, 1'b0);
    checkOutput("mid.ready_rst", 32'(src_ready), 32'h0);
    tick();
    applyStimulus(3'b011, 1'b0, 1'b0);
    checkWrite("mid.after_rst", 1'b0, 5'd0, 32'h0, 3'd0, 1'b0);
    checkOutput("mid.ready1", 32'(src_ready), 32'h1);
    tick();
    applyStimulus(3'b011, 1'b0, 1'b0);
    checkWrite("mid.regrant", 1'b1, 5'd9, 32'h99, 3'd0, 1'b0);
`ifdef WB_RR_EN
    checkOutput("mid.ready2", 32'(src_ready), 32'h2);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkWrite("mid.next", 1'b1, 5'd10, 32'hAA, 3'd1, 1'b0);
`else
    checkOutput("mid.ready2", 32'(src_ready), 32'h1);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkWrite("mid.next", 1'b1, 5'd9, 32'h99, 3'd0, 1'b0);
`endif
    tick();
    checkOutput("end.wr_enable", 32'(wr_enable), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
